// File: rtl/axi_ic_pkg.sv
// Shared definitions for the 2-master / 1-slave AXI interconnect.
// Holds the default response width, the master index type and the
// BRESP encodings used by the write-response return path.
package axi_ic_pkg;

  // Default BRESP width
  localparam int RESP_W_DEF = 2;

  // One bit is enough to name one of the two masters
  typedef logic [0:0] master_idx_t;

  localparam master_idx_t MASTER_M0 = 1'b0;
  localparam master_idx_t MASTER_M1 = 1'b1;

  // BRESP encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Ready of the master that owns the held response
  function automatic logic sel_ready(input master_idx_t sel,
                                     input logic        m0_ready,
                                     input logic        m1_ready);
    logic r;
    case (sel)
      MASTER_M0: r = m0_ready;
      MASTER_M1: r = m1_ready;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/write_resp_router_tag_fifo.sv
// In-order synchronous tag FIFO. Pushes while full and pops while
// empty are dropped. Pointers wrap naturally because DEPTH is a
// power of two; a separate occupancy counter gives full/empty.
module tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == {CW{1'b0}});
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

  // Storage array: write the tag at the write pointer on an accepted push
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // Read/write pointers advance on accepted pop/push, wrapping modulo DEPTH
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= {AW{1'b0}};
      r_rptr <= {AW{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {CW{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/write_resp_router.sv
// Write-response return path for a 2-master / 1-slave AXI interconnect.
// The owner of every accepted AW is queued in an in-order tag FIFO;
// each slave B response is captured into a one-entry output register
// together with the head tag and steered to the owning master.
module write_resp_router
  import axi_ic_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int RESP_W = RESP_W_DEF
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   aw_push,
  input  logic                   aw_master,
  output logic                   aw_accept,
  input  logic                   S_BVALID,
  input  logic [RESP_W-1:0]      S_BRESP,
  output logic                   S_BREADY,
  output logic                   M0_BVALID,
  output logic [RESP_W-1:0]      M0_BRESP,
  input  logic                   M0_BREADY,
  output logic                   M1_BVALID,
  output logic [RESP_W-1:0]      M1_BRESP,
  input  logic                   M1_BREADY,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_unexpected
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Tag FIFO view
  master_idx_t     w_head;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;

  // Output register stage
  logic            r_b_vld;
  master_idx_t     r_b_sel;
  logic [RESP_W-1:0] r_b_resp;
  logic            r_err;

  // Handshake terms
  logic            w_drain;
  logic            w_s_bready;
  logic            w_capture;
  logic            w_unexpected;

  tag_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .i_clk   (ACLK),
    .i_rst_n (ARESETN),
    .i_push  (aw_push),
    .i_din   (aw_master),
    .i_pop   (w_capture),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The held response leaves when its owner is ready; a new one may be
  // captured in that same cycle, so back-to-back responses have no bubble.
  // With no tag queued the slave is held off: there is no bypass path.
  assign w_drain      = r_b_vld && sel_ready(r_b_sel, M0_BREADY, M1_BREADY);
  assign w_s_bready   = !w_empty && (!r_b_vld || w_drain);
  assign w_capture    = S_BVALID && w_s_bready;
  assign w_unexpected = S_BVALID && w_empty && !aw_push;

  assign S_BREADY       = w_s_bready;
  assign aw_accept      = !w_full;
  assign outstanding    = w_count;
  assign err_unexpected = r_err;

  // Output register: capture on slave handshake, clear on drain, else hold
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_b_vld  <= 1'b0;
      r_b_sel  <= MASTER_M0;
      r_b_resp <= {RESP_W{1'b0}};
    end else if (w_capture) begin
      r_b_vld  <= 1'b1;
      r_b_sel  <= w_head;
      r_b_resp <= S_BRESP;
    end else if (w_drain) begin
      r_b_vld  <= 1'b0;
    end
  end

  // Sticky flag for a slave response that arrives with no tag to match
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_err <= 1'b0;
    end else if (w_unexpected) begin
      r_err <= 1'b1;
    end
  end

  // 1-to-2 steering: only the selected master sees VALID and a non-zero code
  always_comb begin
    M0_BVALID = 1'b0;
    M1_BVALID = 1'b0;
    M0_BRESP  = {RESP_W{1'b0}};
    M1_BRESP  = {RESP_W{1'b0}};
    if (r_b_sel == MASTER_M0) begin
      M0_BVALID = r_b_vld;
      M0_BRESP  = r_b_resp;
    end else begin
      M1_BVALID = r_b_vld;
      M1_BRESP  = r_b_resp;
    end
  end

endmodule
